// File: rtl/hash_bsearch_cmp.sv
// hash_bsearch_cmp: binary-searches double-banked key batches against a sorted
// hash table and streams match / batch-end records over a narrow ready/valid bus.
module hash_bsearch_cmp #(
   parameter int unsigned HASH_WIDTH    = 35,
   parameter int unsigned RAM_ADDR_BITS = 12,
   parameter int unsigned NUM_KEYS      = 16,
   parameter int unsigned TAG_WIDTH     = 4,
   parameter int unsigned DOUT_WIDTH    = 4,
   localparam int unsigned KB           = $clog2(NUM_KEYS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     cfg_wr,
   input  logic [RAM_ADDR_BITS-1:0] cfg_addr_start,
   input  logic [RAM_ADDR_BITS-1:0] cfg_addr_diff,
   input  logic                     ram_wr,
   input  logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
   input  logic [HASH_WIDTH:0]      ram_wr_data,
   input  logic                     key_wr,
   input  logic [KB-1:0]            key_wr_idx,
   input  logic [HASH_WIDTH:0]      key_wr_data,
   input  logic                     batch_done,
   input  logic [TAG_WIDTH-1:0]     batch_tag,
   output logic                     bank_free,
   output logic                     idle,
   output logic [DOUT_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     cmp_error
);

   localparam int unsigned EW        = HASH_WIDTH + 1;
   localparam int unsigned DEPTH     = 1 << RAM_ADDR_BITS;
   localparam int unsigned REC_WIDTH = 2 + TAG_WIDTH + KB + RAM_ADDR_BITS;
   localparam int unsigned BEATS     = (REC_WIDTH + DOUT_WIDTH - 1) / DOUT_WIDTH;
   localparam int unsigned PAD_WIDTH = BEATS * DOUT_WIDTH;
   localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {IDLE, READ, CMP, SEND, NEXT} state_t;

   logic [EW-1:0] table_mem [DEPTH];
   logic [EW-1:0] key_mem   [2*NUM_KEYS];
   logic [EW-1:0] tbl_q;

   state_t                         state_q, state_d;
   logic                           wr_bank_q, wr_bank_d;
   logic                           rd_bank_q, rd_bank_d;
   logic [1:0]                     pending_q, pending_d;
   logic [1:0][TAG_WIDTH-1:0]      tag_q, tag_d;
   logic [RAM_ADDR_BITS-1:0]       cfg_start_q, cfg_start_d;
   logic [RAM_ADDR_BITS-1:0]       cfg_diff_q, cfg_diff_d;
   logic [RAM_ADDR_BITS-1:0]       snap_start_q, snap_start_d;
   logic [RAM_ADDR_BITS-1:0]       snap_diff_q, snap_diff_d;
   logic [RAM_ADDR_BITS-1:0]       addr_q, addr_d;
   logic [RAM_ADDR_BITS-1:0]       diff_q, diff_d;
   logic [RAM_ADDR_BITS-1:0]       matches_q, matches_d;
   logic [KB-1:0]                  key_q, key_d;
   logic                           phase_q, phase_d;
   logic                           is_end_q, is_end_d;
   logic [PAD_WIDTH-1:0]           shreg_q, shreg_d;
   logic [BW-1:0]                  beat_q, beat_d;
   logic [DOUT_WIDTH-1:0]          dout_d;
   logic                           dout_valid_d, cmp_error_d, bank_free_d, idle_d;

   logic                           key_wr_ok;
   logic [EW-1:0]                  key_ent;
   logic                           key_v, tbl_v;
   logic [HASH_WIDTH-1:0]          key_h, tbl_h;
   logic                           load;
   logic [REC_WIDTH-1:0]           rec;

   assign key_wr_ok = key_wr & ~pending_q[wr_bank_q];
   assign key_ent   = key_mem[{rd_bank_q, key_q}];
   assign key_v     = key_ent[HASH_WIDTH];
   assign key_h     = key_ent[HASH_WIDTH-1:0];
   assign tbl_v     = tbl_q[HASH_WIDTH];
   assign tbl_h     = tbl_q[HASH_WIDTH-1:0];

   // Table and key storage with registered table read port; contents are not reset
   always_ff @(posedge CLK) begin
      if (ram_wr)
         table_mem[ram_wr_addr] <= ram_wr_data;
      if (key_wr_ok)
         key_mem[{wr_bank_q, key_wr_idx}] <= key_wr_data;
      tbl_q <= table_mem[addr_q];
   end

   // Next-state, bank bookkeeping and output computation
   always_comb begin
      state_d      = state_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      pending_d    = pending_q;
      tag_d        = tag_q;
      cfg_start_d  = cfg_start_q;
      cfg_diff_d   = cfg_diff_q;
      snap_start_d = snap_start_q;
      snap_diff_d  = snap_diff_q;
      addr_d       = addr_q;
      diff_d       = diff_q;
      matches_d    = matches_q;
      key_d        = key_q;
      phase_d      = phase_q;
      is_end_d     = is_end_q;
      shreg_d      = shreg_q;
      beat_d       = beat_q;
      dout_d       = dout;
      dout_valid_d = dout_valid;
      cmp_error_d  = cmp_error;
      load         = 1'b0;
      rec          = '0;

      // producer side: writes into a pending bank are rejected and flagged
      if ((key_wr | batch_done) & pending_q[wr_bank_q])
         cmp_error_d = 1'b1;
      if (batch_done & ~pending_q[wr_bank_q]) begin
         pending_d[wr_bank_q] = 1'b1;
         tag_d[wr_bank_q]     = batch_tag;
         wr_bank_d            = ~wr_bank_q;
      end
      if (cfg_wr) begin
         cfg_start_d = cfg_addr_start;
         cfg_diff_d  = cfg_addr_diff;
      end

      case (state_q)
         IDLE: begin
            if (pending_q[rd_bank_q]) begin
               snap_start_d = cfg_start_q;
               snap_diff_d  = cfg_diff_q;
               key_d        = '0;
               matches_d    = '0;
               state_d      = READ;
            end
         end
         READ: begin
            if (!key_v) begin
               state_d = NEXT;
            end else begin
               addr_d  = snap_start_q;
               diff_d  = snap_diff_q;
               phase_d = 1'b0;
               state_d = CMP;
            end
         end
         CMP: begin
            // phase 0 lets the table read complete, phase 1 decides
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (tbl_v && (key_h == tbl_h)) begin
                  if (matches_q != '1)
                     matches_d = matches_q + RAM_ADDR_BITS'(1);
                  rec      = {addr_q, key_q, tag_q[rd_bank_q], 2'b01};
                  load     = 1'b1;
                  is_end_d = 1'b0;
                  state_d  = SEND;
               end else if (diff_q == '0) begin
                  state_d = NEXT;
               end else begin
                  addr_d = (!tbl_v || (key_h < tbl_h)) ? (addr_q - diff_q) : (addr_q + diff_q);
                  diff_d = diff_q >> 1;
               end
            end
         end
         SEND: begin
            if (dout_ready) begin
               if (beat_q == BW'(BEATS - 1)) begin
                  dout_valid_d = 1'b0;
                  dout_d       = '0;
                  state_d      = is_end_q ? IDLE : NEXT;
               end else begin
                  shreg_d = shreg_q >> DOUT_WIDTH;
                  dout_d  = shreg_d[DOUT_WIDTH-1:0];
                  beat_d  = beat_q + BW'(1);
               end
            end
         end
         NEXT: begin
            if (key_q == KB'(NUM_KEYS - 1)) begin
               rec                  = {matches_q, key_q, tag_q[rd_bank_q], 2'b10};
               load                 = 1'b1;
               is_end_d             = 1'b1;
               pending_d[rd_bank_q] = 1'b0;
               rd_bank_d            = ~rd_bank_q;
               state_d              = SEND;
            end else begin
               key_d   = key_q + KB'(1);
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase

      // start serialising a new record, LSB beat first
      if (load) begin
         shreg_d      = PAD_WIDTH'(rec);
         dout_d       = shreg_d[DOUT_WIDTH-1:0];
         dout_valid_d = 1'b1;
         beat_d       = '0;
      end

      bank_free_d = ~pending_d[wr_bank_d];
      idle_d      = (state_d == IDLE) && (pending_d == 2'b00);
   end

   // State and output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         pending_q    <= '0;
         tag_q        <= '0;
         cfg_start_q  <= RAM_ADDR_BITS'(DEPTH / 2);
         cfg_diff_q   <= RAM_ADDR_BITS'(DEPTH / 4);
         snap_start_q <= '0;
         snap_diff_q  <= '0;
         addr_q       <= '0;
         diff_q       <= '0;
         matches_q    <= '0;
         key_q        <= '0;
         phase_q      <= 1'b0;
         is_end_q     <= 1'b0;
         shreg_q      <= '0;
         beat_q       <= '0;
         dout         <= '0;
         dout_valid   <= 1'b0;
         cmp_error    <= 1'b0;
         bank_free    <= 1'b1;
         idle         <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         pending_q    <= pending_d;
         tag_q        <= tag_d;
         cfg_start_q  <= cfg_start_d;
         cfg_diff_q   <= cfg_diff_d;
         snap_start_q <= snap_start_d;
         snap_diff_q  <= snap_diff_d;
         addr_q       <= addr_d;
         diff_q       <= diff_d;
         matches_q    <= matches_d;
         key_q        <= key_d;
         phase_q      <= phase_d;
         is_end_q     <= is_end_d;
         shreg_q      <= shreg_d;
         beat_q       <= beat_d;
         dout         <= dout_d;
         dout_valid   <= dout_valid_d;
         cmp_error    <= cmp_error_d;
         bank_free    <= bank_free_d;
         idle         <= idle_d;
      end
   end

endmodule
